idli_mem_arb_m: RTL and testbench
=================================

# idli_mem_arb_m

Scheduler for the single SQI memory engine, sharing it between the instruction-fetch stream and the load/store unit. It keeps a sequential read stream open for fetch and tracks the fetch address. When a data access is pending, it closes the stream on a word boundary, runs one data word, and then reopens fetch at the saved address. It sits between the core (decode/execute/pc) and the SQI engine's command port.

## Interface
- RESET_PC, 16'h0000: fetch address loaded on reset.
- ADDR_W, 16: address width in bits.
- i_arb_gck  in  1  core clock.
- i_arb_rst_n  in  1  reset. Asynchronous, active-low.
- i_arb_fetch_req  in  1  fetch stream wanted; low means the consumer is stalled.
- o_arb_fetch_gnt  out  1  engine beats currently belong to fetch.
- i_arb_redirect  in  1  one-cycle pulse that loads a new fetch address.
- i_arb_redirect_addr  in  ADDR_W  new fetch address.
- i_arb_ldst_req  in  1  data access request. Held until o_arb_ldst_gnt.
- i_arb_ldst_wr  in  1  1 = store, 0 = load. Stable while req is high.
- i_arb_ldst_addr  in  ADDR_W  data word address. Stable while req is high.
- o_arb_ldst_gnt  out  1  one-cycle pulse: request accepted.
- o_arb_ldst_done  out  1  one-cycle pulse: data word transferred.
- o_arb_eng_start  out  1  one-cycle pulse: open a transaction.
- o_arb_eng_wr  out  1  transaction direction. Valid with start.
- o_arb_eng_addr  out  ADDR_W  transaction start address. Valid with start.
- o_arb_eng_stop  out  1  one-cycle pulse: close the transaction (deassert CS).
- i_arb_eng_busy  in  1  engine has an open or closing transaction.
- i_arb_eng_beat  in  1  one-cycle pulse: one full 16-bit word transferred.

## Operation
- All outputs are registered. The reset value of every output is 0.
- The fetch counter resets to RESET_PC. The fairness flag (fetch_owed) resets to 0.
- States are IDLE, F_START, F_RUN, F_STOP, D_START, D_RUN, D_STOP. Reset enters IDLE from any state, including mid-transaction. The engine is reset by the same signal.
- IDLE: wait until !eng_busy, then choose the next transaction:
  - if ldst_req and !(fetch_owed && fetch_req), go to D_START;
  - else if fetch_req, go to F_START;
  - otherwise stay in IDLE.
- F_START: pulse eng_start with wr=0 and addr=fetch counter, clear fetch_owed, go to F_RUN.
- F_RUN: fetch_gnt=1.
  - On each eng_beat, fetch counter += 1.
  - On redirect, go to F_STOP at once (partial word abandoned).
  - Otherwise, on a beat with (ldst_req || !fetch_req), go to F_STOP.
- F_STOP: pulse eng_stop in the entry cycle only, fetch_gnt=0. Wait for !eng_busy, then go to IDLE.
- D_START: pulse eng_start with wr=ldst_wr and addr=ldst_addr, pulse ldst_gnt, go to D_RUN.
- D_RUN: on eng_beat, pulse ldst_done, set fetch_owed=1, go to D_STOP.
- D_STOP: same as F_STOP.
- Redirect in any state loads the fetch counter with redirect_addr. It forces a state change only from F_RUN.
- Redirect and beat in the same cycle: redirect wins and the beat is not counted.
- The fetch counter wraps from 16'hFFFF to 16'h0000.
- A data access is exactly one word. Back-to-back data requests alternate with fetch whenever fetch_req is high, so neither requester starves.

## Timing
- Fetch from idle: req seen in IDLE at cycle n, eng_start at n+1, fetch_gnt at n+2.
- Data from idle: ldst_req at n, eng_start and ldst_gnt at n+1.
- ldst_done is registered in the cycle after the eng_beat is sampled.
- Preemption: ldst_req during F_RUN means eng_stop one cycle after the next fetch beat. Data eng_start follows 1 cycle after busy falls plus 1 IDLE cycle.
- Resume after data: fetch eng_start with addr equal to the counter value at preemption. No fetch word is lost or repeated.
- eng_start and eng_stop are never high in the same cycle, and never high while in IDLE.
- eng_start is never issued while eng_busy is high.

## Test plan
- Reset, fetch_req=1, RESET_PC=0: eng_start at cycle 2 with addr=0, wr=0. After 3 beats the counter is 3 and fetch_gnt is held.
- Fetching at 0x0010, ldst_req load at 0x8000 mid-word:
  - eng_stop only after the beat that moves the counter to 0x0011;
  - then start(addr=0x8000, wr=0), gnt, beat, done;
  - then start(addr=0x0011, wr=0).
- Redirect to 0x0200 coincident with a beat during F_RUN: immediate stop, beat not counted, next start addr=0x0200.
- ldst_req store held high across 3 accesses with fetch_req=1: order is data, fetch (≥1 beat), data, fetch, data. Each eng_wr=1.
- Counter at 0xFFFF plus one beat: next resume address is 0x0000.
- Async reset asserted in D_RUN: all outputs 0 immediately, state IDLE, counter=RESET_PC, no ldst_done. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/idli_mem_arb_m.sv
// idli_mem_arb_m: shares the single SQI engine between the sequential fetch
// stream and one-word load/store accesses, resuming fetch where it stopped.
module idli_mem_arb_m #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_arb_gck,
  input  logic              i_arb_rst_n,
  input  logic              i_arb_fetch_req,
  output logic              o_arb_fetch_gnt,
  input  logic              i_arb_redirect,
  input  logic [ADDR_W-1:0] i_arb_redirect_addr,
  input  logic              i_arb_ldst_req,
  input  logic              i_arb_ldst_wr,
  input  logic [ADDR_W-1:0] i_arb_ldst_addr,
  output logic              o_arb_ldst_gnt,
  output logic              o_arb_ldst_done,
  output logic              o_arb_eng_start,
  output logic              o_arb_eng_wr,
  output logic [ADDR_W-1:0] o_arb_eng_addr,
  output logic              o_arb_eng_stop,
  input  logic              i_arb_eng_busy,
  input  logic              i_arb_eng_beat
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_F_START = 3'd1;
  localparam logic [2:0] S_F_RUN   = 3'd2;
  localparam logic [2:0] S_F_STOP  = 3'd3;
  localparam logic [2:0] S_D_START = 3'd4;
  localparam logic [2:0] S_D_RUN   = 3'd5;
  localparam logic [2:0] S_D_STOP  = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] fetch_cnt;
  logic [ADDR_W-1:0] fetch_cnt_nxt;
  logic              fetch_owed;
  logic              start_f;
  logic              start_d;
  logic              stop_entry;

  // fetch_owed lets fetch win the next idle slot after a data word, so a
  // held data request cannot starve the instruction stream
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!i_arb_eng_busy) begin
          if (i_arb_ldst_req && !(fetch_owed && i_arb_fetch_req)) begin
            state_nxt = S_D_START;
          end else if (i_arb_fetch_req) begin
            state_nxt = S_F_START;
          end
        end
      end
      S_F_START: state_nxt = S_F_RUN;
      S_F_RUN: begin
        if (i_arb_redirect) begin
          state_nxt = S_F_STOP;
        end else if (i_arb_eng_beat && (i_arb_ldst_req || !i_arb_fetch_req)) begin
          state_nxt = S_F_STOP;
        end
      end
      S_F_STOP, S_D_STOP: begin
        if (!i_arb_eng_busy) begin
          state_nxt = S_IDLE;
        end
      end
      S_D_START: state_nxt = S_D_RUN;
      S_D_RUN: begin
        if (i_arb_eng_beat) begin
          state_nxt = S_D_STOP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Redirect overrides a same-cycle beat; only beats inside the fetch stream advance
  always_comb begin
    fetch_cnt_nxt = fetch_cnt;
    if (i_arb_redirect) begin
      fetch_cnt_nxt = i_arb_redirect_addr;
    end else if ((state == S_F_RUN) && i_arb_eng_beat) begin
      fetch_cnt_nxt = fetch_cnt + 1'b1;
    end
  end

  assign start_f    = (state == S_IDLE) && (state_nxt == S_F_START);
  assign start_d    = (state == S_IDLE) && (state_nxt == S_D_START);
  assign stop_entry = ((state_nxt == S_F_STOP) || (state_nxt == S_D_STOP)) &&
                      (state != state_nxt);

  always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
    if (!i_arb_rst_n) begin
      state           <= S_IDLE;
      fetch_cnt       <= RESET_PC;
      fetch_owed      <= 1'b0;
      o_arb_fetch_gnt <= 1'b0;
      o_arb_ldst_gnt  <= 1'b0;
      o_arb_ldst_done <= 1'b0;
      o_arb_eng_start <= 1'b0;
      o_arb_eng_wr    <= 1'b0;
      o_arb_eng_addr  <= '0;
      o_arb_eng_stop  <= 1'b0;
    end else begin
      state           <= state_nxt;
      fetch_cnt       <= fetch_cnt_nxt;
      o_arb_eng_start <= start_f || start_d;
      o_arb_ldst_gnt  <= start_d;
      o_arb_eng_stop  <= stop_entry;
      o_arb_fetch_gnt <= (state_nxt == S_F_RUN);
      o_arb_ldst_done <= (state == S_D_RUN) && i_arb_eng_beat;
      if (start_f) begin
        o_arb_eng_wr   <= 1'b0;
        o_arb_eng_addr <= fetch_cnt_nxt;
      end else if (start_d) begin
        o_arb_eng_wr   <= i_arb_ldst_wr;
        o_arb_eng_addr <= i_arb_ldst_addr;
      end
      if (state == S_F_START) begin
        fetch_owed <= 1'b0;
      end else if ((state == S_D_RUN) && i_arb_eng_beat) begin
        fetch_owed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// tb_idli_mem_arb_m: directed bench with a small SQI engine model; the
// arbiter's start/stop/grant/done/beat events are logged and compared to tables.
module tb_idli_mem_arb_m;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int EV_START = 1;
  localparam int EV_STOP  = 2;
  localparam int EV_GNT   = 3;
  localparam int EV_DONE  = 4;
  localparam int EV_FBEAT = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_arb_fetch_req;
  logic        o_arb_fetch_gnt;
  logic        i_arb_redirect;
  logic [15:0] i_arb_redirect_addr;
  logic        i_arb_ldst_req;
  logic        i_arb_ldst_wr;
  logic [15:0] i_arb_ldst_addr;
  logic        o_arb_ldst_gnt;
  logic        o_arb_ldst_done;
  logic        o_arb_eng_start;
  logic        o_arb_eng_wr;
  logic [15:0] o_arb_eng_addr;
  logic        o_arb_eng_stop;
  logic        i_arb_eng_busy;
  logic        i_arb_eng_beat;

  always #5 clk = ~clk;

  idli_mem_arb_m #(.ADDR_W(16), .RESET_PC(RESET_PC)) dut (
    .i_arb_gck           (clk),
    .i_arb_rst_n         (rst_n),
    .i_arb_fetch_req     (i_arb_fetch_req),
    .o_arb_fetch_gnt     (o_arb_fetch_gnt),
    .i_arb_redirect      (i_arb_redirect),
    .i_arb_redirect_addr (i_arb_redirect_addr),
    .i_arb_ldst_req      (i_arb_ldst_req),
    .i_arb_ldst_wr       (i_arb_ldst_wr),
    .i_arb_ldst_addr     (i_arb_ldst_addr),
    .o_arb_ldst_gnt      (o_arb_ldst_gnt),
    .o_arb_ldst_done     (o_arb_ldst_done),
    .o_arb_eng_start     (o_arb_eng_start),
    .o_arb_eng_wr        (o_arb_eng_wr),
    .o_arb_eng_addr      (o_arb_eng_addr),
    .o_arb_eng_stop      (o_arb_eng_stop),
    .i_arb_eng_busy      (i_arb_eng_busy),
    .i_arb_eng_beat      (i_arb_eng_beat)
  );

  int          checks = 0;
  int          errors = 0;
  int          viol = 0;
  int          ev_q[$];
  int          exp_q[$];
  int          beat_div = 3;
  bit          eng_open = 1'b0;
  int          beat_ctr = 0;
  int          close_ctr = 0;
  bit          redir_pulse = 1'b0;
  bit          redir_on_beat = 1'b0;
  logic [15:0] redir_target = 16'h0000;
  int          ldst_left = 0;

  function automatic int ev_code(int kind, logic wr, logic [15:0] addr);
    return (kind << 17) | (int'(wr) << 16) | int'(addr);
  endfunction

  function automatic logic [21:0] outs_vec();
    return {o_arb_fetch_gnt, o_arb_ldst_gnt, o_arb_ldst_done, o_arb_eng_start,
            o_arb_eng_wr, o_arb_eng_stop, o_arb_eng_addr};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Engine model: beat every beat_div open cycles, busy lingers 2 cycles after stop
  task automatic engineModel();
    i_arb_eng_beat = 1'b0;
    i_arb_redirect = 1'b0;
    if (!rst_n) begin
      eng_open  = 1'b0;
      close_ctr = 0;
      beat_ctr  = 0;
    end else if (o_arb_eng_stop) begin
      eng_open  = 1'b0;
      close_ctr = 2;
    end else if (o_arb_eng_start) begin
      eng_open = 1'b1;
      beat_ctr = 0;
    end else if (eng_open) begin
      beat_ctr++;
      if (beat_ctr == beat_div) begin
        i_arb_eng_beat = 1'b1;
        beat_ctr = 0;
      end
    end
    i_arb_eng_busy = eng_open || (close_ctr > 0);
    if (close_ctr > 0) close_ctr--;
    if (redir_pulse) begin
      i_arb_redirect = 1'b1;
      redir_pulse = 1'b0;
    end else if (redir_on_beat && i_arb_eng_beat && o_arb_fetch_gnt) begin
      i_arb_redirect = 1'b1;
      redir_on_beat = 1'b0;
    end
    i_arb_redirect_addr = redir_target;
    if (i_arb_eng_beat && o_arb_fetch_gnt && !i_arb_redirect)
      ev_q.push_back(ev_code(EV_FBEAT, 1'b0, 16'h0));
  endtask

  // One clock: drive engine inputs on the falling edge, log outputs after the rising edge
  task automatic applyStimulus();
    @(negedge clk);
    engineModel();
    @(posedge clk);
    #1;
    if (o_arb_eng_start) begin
      ev_q.push_back(ev_code(EV_START, o_arb_eng_wr, o_arb_eng_addr));
      if (i_arb_eng_busy || o_arb_eng_stop) viol++;
    end
    if (o_arb_ldst_gnt) begin
      ev_q.push_back(ev_code(EV_GNT, 1'b0, 16'h0));
      if (ldst_left > 0) ldst_left--;
      if (ldst_left == 0) i_arb_ldst_req = 1'b0;
    end
    if (o_arb_ldst_done) ev_q.push_back(ev_code(EV_DONE, 1'b0, 16'h0));
    if (o_arb_eng_stop) ev_q.push_back(ev_code(EV_STOP, 1'b0, 16'h0));
  endtask

  task automatic runEvents(input string tag, input int n, input int max_cycles);
    int cyc;
    cyc = 0;
    while ((ev_q.size() < n) && (cyc < max_cycles)) begin
      applyStimulus();
      cyc++;
    end
    checkOutput({tag, "_evcount"}, 32'(ev_q.size() >= n), 32'd1);
  endtask

  task automatic compareEvents(input string tag);
    int act;
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < ev_q.size()) ? ev_q[i] : -1;
      checkOutput($sformatf("%s[%0d]", tag, i), act, exp_q[i]);
    end
  endtask

  task automatic redirectCheck(input string tag, input logic [15:0] target,
                               input bit on_beat);
    ev_q.delete();
    redir_target = target;
    if (on_beat) redir_on_beat = 1'b1;
    else redir_pulse = 1'b1;
    runEvents(tag, 2, 40);
    exp_q = '{ev_code(EV_STOP, 1'b0, 16'h0), ev_code(EV_START, 1'b0, target)};
    compareEvents(tag);
  endtask

  task automatic preemptCheck(input string tag, input logic [15:0] daddr,
                              input logic dwr, input logic [15:0] resume);
    ev_q.delete();
    i_arb_ldst_addr = daddr;
    i_arb_ldst_wr   = dwr;
    i_arb_ldst_req  = 1'b1;
    ldst_left       = 1;
    runEvents(tag, 7, 80);
    exp_q = '{ev_code(EV_FBEAT, 1'b0, 16'h0), ev_code(EV_STOP, 1'b0, 16'h0),
              ev_code(EV_START, dwr, daddr), ev_code(EV_GNT, 1'b0, 16'h0),
              ev_code(EV_DONE, 1'b0, 16'h0), ev_code(EV_STOP, 1'b0, 16'h0),
              ev_code(EV_START, 1'b0, resume)};
    compareEvents(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done_seen;
    rst_n               = 1'b0;
    i_arb_fetch_req     = 1'b0;
    i_arb_redirect      = 1'b0;
    i_arb_redirect_addr = 16'h0;
    i_arb_ldst_req      = 1'b0;
    i_arb_ldst_wr       = 1'b0;
    i_arb_ldst_addr     = 16'h0;
    i_arb_eng_busy      = 1'b0;
    i_arb_eng_beat      = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("reset_outs", 32'(outs_vec()), 32'h0);

    // Boot: start one cycle after release, grant the cycle after
    rst_n = 1'b1;
    i_arb_fetch_req = 1'b1;
    ev_q.delete();
    applyStimulus();
    checkOutput("boot_start", 32'(o_arb_eng_start), 32'd1);
    checkOutput("boot_addr", 32'(o_arb_eng_addr), 32'(RESET_PC));
    checkOutput("boot_wr", 32'(o_arb_eng_wr), 32'd0);
    applyStimulus();
    checkOutput("boot_gnt", 32'(o_arb_fetch_gnt), 32'd1);
    ev_q.delete();
    runEvents("three_beats", 3, 40);
    checkOutput("gnt_held", 32'(o_arb_fetch_gnt), 32'd1);

    preemptCheck("pre_at3", 16'h8000, 1'b0, 16'h0004);
    redirectCheck("redir_beat", 16'h0200, 1'b1);
    applyStimulus();
    redirectCheck("redir_0010", 16'h0010, 1'b0);
    applyStimulus();
    preemptCheck("pre_0010", 16'h8000, 1'b0, 16'h0011);

    // Held store request: data and fetch alternate, each fetch gets one beat
    ev_q.delete();
    i_arb_ldst_addr = 16'h1234;
    i_arb_ldst_wr   = 1'b1;
    i_arb_ldst_req  = 1'b1;
    ldst_left       = 3;
    runEvents("alt", 21, 300);
    exp_q = '{};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ev_code(EV_FBEAT, 1'b0, 16'h0));
      exp_q.push_back(ev_code(EV_STOP, 1'b0, 16'h0));
      exp_q.push_back(ev_code(EV_START, 1'b1, 16'h1234));
      exp_q.push_back(ev_code(EV_GNT, 1'b0, 16'h0));
      exp_q.push_back(ev_code(EV_DONE, 1'b0, 16'h0));
      exp_q.push_back(ev_code(EV_STOP, 1'b0, 16'h0));
      exp_q.push_back(ev_code(EV_START, 1'b0, 16'(16'h0012 + k)));
    end
    compareEvents("alt");

    applyStimulus();
    redirectCheck("redir_ffff", 16'hFFFF, 1'b0);
    applyStimulus();
    preemptCheck("wrap", 16'h0042, 1'b0, 16'h0000);

    // Reset while the data word is in flight
    ev_q.delete();
    i_arb_ldst_addr = 16'h0055;
    i_arb_ldst_wr   = 1'b0;
    i_arb_ldst_req  = 1'b1;
    ldst_left       = 1;
    runEvents("to_drun", 4, 60);
    applyStimulus();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_outs", 32'(outs_vec()), 32'h0);
    repeat (4) applyStimulus();
    done_seen = 0;
    foreach (ev_q[i]) if (ev_q[i] == ev_code(EV_DONE, 1'b0, 16'h0)) done_seen++;
    checkOutput("rst_no_done", done_seen, 0);
    ev_q.delete();
    rst_n = 1'b1;
    runEvents("restart", 1, 10);
    exp_q = '{ev_code(EV_START, 1'b0, RESET_PC)};
    compareEvents("restart");

    checkOutput("invariants", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
